// File: rtl/th99_bus_pkg.sv
// Shared constants, register map and bus FSM state type for the TH99CHLS
// microcontroller bus decoder.
package th99_bus_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 16;
    localparam int NUM_REGS = 10;

    localparam logic [ADDR_W-1:0] B0_ADDR      = 16'd0;
    localparam logic [ADDR_W-1:0] B1_ADDR      = 16'd1;
    localparam logic [ADDR_W-1:0] B2_ADDR      = 16'd2;
    localparam logic [ADDR_W-1:0] B3_ADDR      = 16'd3;
    localparam logic [ADDR_W-1:0] B4_ADDR      = 16'd4;
    localparam logic [ADDR_W-1:0] B5_ADDR      = 16'd5;
    localparam logic [ADDR_W-1:0] B6_ADDR      = 16'd6;
    localparam logic [ADDR_W-1:0] OPERAND_ADDR = 16'd7;
    localparam logic [ADDR_W-1:0] HOUR_ADDR    = 16'd8;
    localparam logic [ADDR_W-1:0] MINUTE_ADDR  = 16'd9;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        HOLD,
        READ
    } bus_state_t;

endpackage

// File: rtl/mcu_bus_fsm.sv
// Address latch and transaction state machine for the multiplexed MCU bus.
// The READ state exists only when REG_READBACK_EN is defined.
module mcu_bus_fsm
    import th99_bus_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        abus,
    input  logic [DATA_W-1:0] dbus_in,
    input  logic              csbar,
    input  logic              ale,
    input  logic              rbar,
    input  logic              wbar,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr_q
);

    bus_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_d;

    // wr_en/rd_en are combinational so the commit lands on the transition edge.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!csbar && ale) begin
                    addr_d  = {abus, dbus_in};
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (csbar) begin
                    state_d = IDLE;
                end else if (ale) begin
                    addr_d = {abus, dbus_in};
                end else if (!wbar) begin
                    wr_en   = 1'b1;
                    state_d = HOLD;
                end else if (!rbar) begin
`ifdef REG_READBACK_EN
                    rd_en   = 1'b1;
                    state_d = READ;
`else
                    state_d = HOLD;
`endif
                end
            end
            HOLD: begin
                if (csbar) begin
                    state_d = IDLE;
                end
            end
`ifdef REG_READBACK_EN
            READ: begin
                if (csbar) begin
                    state_d = IDLE;
                end else begin
                    rd_en = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: rtl/mcu_bus_regfile.sv
// Configuration register file behind the MCU bus: coefficients, operand and
// time presets with range checks. Readback depends on REG_READBACK_EN.
module mcu_bus_regfile #(
    parameter int NUM_B    = 7,
    parameter int DATA_W   = 8,
    parameter int HOUR_MAX = 23,
    parameter int MIN_MAX  = 59
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              abus,
    input  logic [DATA_W-1:0]       dbus_in,
    output logic [DATA_W-1:0]       dbus_out,
    output logic                    dbus_oe,
    input  logic                    csbar,
    input  logic                    ale,
    input  logic                    rbar,
    input  logic                    wbar,
    output logic [NUM_B*DATA_W-1:0] b_flat,
    output logic [DATA_W-1:0]       operand,
    output logic [DATA_W-1:0]       hour_preset,
    output logic [DATA_W-1:0]       minute_preset,
    output logic                    time_load,
    output logic                    bus_err
);

    import th99_bus_pkg::*;

    localparam logic [DATA_W-1:0] HOUR_LIM = DATA_W'(HOUR_MAX);
    localparam logic [DATA_W-1:0] MIN_LIM  = DATA_W'(MIN_MAX);

    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr_q;
    logic              addr_legal;
    logic              is_hour;
    logic              is_minute;
    logic [3:0]        idx;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] dbus_out_q, dbus_out_d;
    logic              dbus_oe_q, dbus_oe_d;
    logic              time_load_q, time_load_d;
    logic              bus_err_q, bus_err_d;

    mcu_bus_fsm u_fsm (
        .clock   (clock),
        .reset   (reset),
        .abus    (abus),
        .dbus_in (dbus_in),
        .csbar   (csbar),
        .ale     (ale),
        .rbar    (rbar),
        .wbar    (wbar),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .addr_q  (addr_q)
    );

    assign addr_legal = (addr_q <= MINUTE_ADDR);
    assign is_hour    = (addr_q == HOUR_ADDR);
    assign is_minute  = (addr_q == MINUTE_ADDR);
    assign idx        = addr_q[3:0];

    always_comb begin
        regs_d      = regs_q;
        time_load_d = 1'b0;
        bus_err_d   = bus_err_q;
        dbus_oe_d   = rd_en;
        dbus_out_d  = '0;
        if (wr_en) begin
            if (!addr_legal) begin
                bus_err_d = 1'b1;
            end else if ((is_hour && (dbus_in > HOUR_LIM)) ||
                         (is_minute && (dbus_in > MIN_LIM))) begin
                bus_err_d = 1'b1;
            end else begin
                regs_d[idx] = dbus_in;
                time_load_d = is_hour || is_minute;
            end
        end
        // rd_en is constant 0 without readback, so these flops stay at reset.
        if (rd_en) begin
            if (addr_legal) begin
                dbus_out_d = regs_q[idx];
            end else begin
                dbus_out_d = '1;
                bus_err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q      <= '{default: '0};
            dbus_out_q  <= '0;
            dbus_oe_q   <= 1'b0;
            time_load_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            dbus_out_q  <= dbus_out_d;
            dbus_oe_q   <= dbus_oe_d;
            time_load_q <= time_load_d;
            bus_err_q   <= bus_err_d;
        end
    end

    for (genvar g = 0; g < NUM_B; g++) begin : g_bflat
        assign b_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign operand       = regs_q[OPERAND_ADDR[3:0]];
    assign hour_preset   = regs_q[HOUR_ADDR[3:0]];
    assign minute_preset = regs_q[MINUTE_ADDR[3:0]];
    assign dbus_out      = dbus_out_q;
    assign dbus_oe       = dbus_oe_q;
    assign time_load     = time_load_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mcu_bus_regfile.sv
// Self-checking bench for mcu_bus_regfile; readback checks follow REG_READBACK_EN.
module tb_mcu_bus_regfile;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  abus;
    logic [7:0]  dbus_in;
    logic [7:0]  dbus_out;
    logic        dbus_oe;
    logic        csbar;
    logic        ale;
    logic        rbar;
    logic        wbar;
    logic [55:0] b_flat;
    logic [7:0]  operand;
    logic [7:0]  hour_preset;
    logic [7:0]  minute_preset;
    logic        time_load;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] model [10];
    logic       model_err;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        bit          accept;
        bit          tl;
        bit          err;
    } vec_t;

    vec_t vecs [16];

    mcu_bus_regfile #(
        .NUM_B    (7),
        .DATA_W   (8),
        .HOUR_MAX (23),
        .MIN_MAX  (59)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .abus          (abus),
        .dbus_in       (dbus_in),
        .dbus_out      (dbus_out),
        .dbus_oe       (dbus_oe),
        .csbar         (csbar),
        .ale           (ale),
        .rbar          (rbar),
        .wbar          (wbar),
        .b_flat        (b_flat),
        .operand       (operand),
        .hour_preset   (hour_preset),
        .minute_preset (minute_preset),
        .time_load     (time_load),
        .bus_err       (bus_err)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string name);
        logic [55:0] exp_b;
        for (int i = 0; i < 7; i++) exp_b[i*8 +: 8] = model[i];
        chk({name, " b_flat"}, {8'h0, b_flat}, {8'h0, exp_b});
        chk({name, " operand"}, {56'h0, operand}, {56'h0, model[7]});
        chk({name, " hour"}, {56'h0, hour_preset}, {56'h0, model[8]});
        chk({name, " minute"}, {56'h0, minute_preset}, {56'h0, model[9]});
        chk({name, " bus_err"}, {63'h0, bus_err}, {63'h0, model_err});
    endtask

    task automatic idle_bus();
        csbar   = 1'b1;
        ale     = 1'b0;
        rbar    = 1'b1;
        wbar    = 1'b1;
        abus    = 8'h00;
        dbus_in = 8'h00;
    endtask

    task automatic addr_phase(input logic [15:0] addr);
        csbar   = 1'b0;
        ale     = 1'b1;
        abus    = addr[15:8];
        dbus_in = addr[7:0];
        tick();
    endtask

    // ALE edge, commit edge, then one cycle with csbar high.
    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data,
                             input bit exp_tl, input string name);
        addr_phase(addr);
        ale     = 1'b0;
        wbar    = 1'b0;
        dbus_in = data;
        tick();
        chk({name, " time_load pulse"}, {63'h0, time_load}, {63'h0, exp_tl});
        idle_bus();
        tick();
        chk({name, " time_load end"}, {63'h0, time_load}, 64'h0);
    endtask

    initial begin
        vecs[0]  = '{16'd0,   8'd13,  1'b1, 1'b0, 1'b0};
        vecs[1]  = '{16'd1,   8'd89,  1'b1, 1'b0, 1'b0};
        vecs[2]  = '{16'd2,   8'd73,  1'b1, 1'b0, 1'b0};
        vecs[3]  = '{16'd3,   8'd59,  1'b1, 1'b0, 1'b0};
        vecs[4]  = '{16'd4,   8'd23,  1'b1, 1'b0, 1'b0};
        vecs[5]  = '{16'd5,   8'd67,  1'b1, 1'b0, 1'b0};
        vecs[6]  = '{16'd6,   8'd1,   1'b1, 1'b0, 1'b0};
        vecs[7]  = '{16'd7,   8'hED,  1'b1, 1'b0, 1'b0};
        vecs[8]  = '{16'd8,   8'd23,  1'b1, 1'b1, 1'b0};
        vecs[9]  = '{16'd9,   8'd33,  1'b1, 1'b1, 1'b0};
        vecs[10] = '{16'd8,   8'd24,  1'b0, 1'b0, 1'b1};
        vecs[11] = '{16'd10,  8'd5,   1'b0, 1'b0, 1'b1};
        vecs[12] = '{16'd9,   8'd59,  1'b1, 1'b1, 1'b1};
        vecs[13] = '{16'd9,   8'd60,  1'b0, 1'b0, 1'b1};
        vecs[14] = '{16'h0100, 8'd44, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{16'd9,   8'd33,  1'b1, 1'b1, 1'b1};

        for (int i = 0; i < 10; i++) model[i] = 8'h00;
        model_err = 1'b0;

        idle_bus();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk_regs("reset");
        chk("reset dbus_oe", {63'h0, dbus_oe}, 64'h0);
        chk("reset dbus_out", {56'h0, dbus_out}, 64'h0);
        chk("reset time_load", {63'h0, time_load}, 64'h0);

        for (int v = 0; v < 16; v++) begin
            bus_write(vecs[v].addr, vecs[v].data, vecs[v].tl, $sformatf("vec%0d", v));
            if (vecs[v].accept) model[vecs[v].addr[3:0]] = vecs[v].data;
            model_err = vecs[v].err;
            chk_regs($sformatf("vec%0d", v));
        end

        // Strobes held low: only the first data value commits.
        addr_phase(16'd5);
        ale = 1'b0;
        tick();
        tick();
        wbar    = 1'b0;
        dbus_in = 8'h11;
        tick();
        dbus_in = 8'h22;
        tick();
        tick();
        idle_bus();
        tick();
        model[5] = 8'h11;
        chk_regs("single commit per cs");

        // Abort from ADDR: csbar rises with wbar low.
        addr_phase(16'd6);
        csbar   = 1'b1;
        ale     = 1'b0;
        wbar    = 1'b0;
        dbus_in = 8'hAA;
        tick();
        idle_bus();
        tick();
        chk_regs("abort");

        // Write wins over read when both strobes are low.
        addr_phase(16'd4);
        ale     = 1'b0;
        wbar    = 1'b0;
        rbar    = 1'b0;
        dbus_in = 8'h3C;
        tick();
        chk("wr prio dbus_oe", {63'h0, dbus_oe}, 64'h0);
        idle_bus();
        tick();
        model[4] = 8'h3C;
        chk_regs("wr prio");

`ifdef REG_READBACK_EN
        addr_phase(16'd9);
        ale  = 1'b0;
        rbar = 1'b0;
        tick();
        chk("read oe", {63'h0, dbus_oe}, 64'h1);
        chk("read data", {56'h0, dbus_out}, 64'd33);
        rbar = 1'b1;
        tick();
        chk("read oe hold", {63'h0, dbus_oe}, 64'h1);
        chk("read data hold", {56'h0, dbus_out}, 64'd33);
        idle_bus();
        tick();
        chk("read oe drop", {63'h0, dbus_oe}, 64'h0);
`endif

        // Reset while a write is pending in ADDR.
        addr_phase(16'd3);
        ale     = 1'b0;
        wbar    = 1'b0;
        dbus_in = 8'h77;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        idle_bus();
        for (int i = 0; i < 10; i++) model[i] = 8'h00;
        model_err = 1'b0;
        chk_regs("mid reset");
        chk("mid reset dbus_oe", {63'h0, dbus_oe}, 64'h0);
        tick();

        // Read strobe: no side effects without readback, legal readback with it.
        addr_phase(16'd1);
        ale  = 1'b0;
        rbar = 1'b0;
        tick();
`ifdef REG_READBACK_EN
        chk("post reset read oe", {63'h0, dbus_oe}, 64'h1);
`else
        chk("no readback oe", {63'h0, dbus_oe}, 64'h0);
`endif
        chk("no readback data", {56'h0, dbus_out}, 64'h0);
        idle_bus();
        tick();
        chk_regs("after read strobe");

        bus_write(16'd2, 8'd5, 1'b0, "post reset write");
        model[2] = 8'd5;
        chk_regs("post reset write");

`ifdef REG_READBACK_EN
        addr_phase(16'd12);
        ale  = 1'b0;
        rbar = 1'b0;
        tick();
        chk("illegal read data", {56'h0, dbus_out}, 64'hFF);
        chk("illegal read err", {63'h0, bus_err}, 64'h1);
        idle_bus();
        tick();
        model_err = 1'b1;
        chk_regs("illegal read");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
